// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared types, widths and response-count helper for the blit scheduler
package blit_pkg;

  localparam int COORD_W    = 11;
  localparam int BURST_MAX  = 16;
  localparam int RESP_CNT_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM,
    DRAIN
  } blit_state_e;

  // One write response per writer burst: ceil((w+1)/BURST_MAX) bursts per line, h+1 lines.
  function automatic logic [RESP_CNT_W-1:0] resp_total(input logic [COORD_W-1:0] w,
                                                       input logic [COORD_W-1:0] h);
    logic [COORD_W:0]    line_bursts;
    logic [RESP_CNT_W-1:0] lines;
    line_bursts = ({1'b0, w} + (COORD_W+1)'(BURST_MAX)) >> $clog2(BURST_MAX);
    lines       = RESP_CNT_W'({1'b0, h}) + RESP_CNT_W'(1);
    return RESP_CNT_W'(line_bursts) * lines;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx,
  output logic            any
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        grant_idx = 3'(j);
      end
    end
  end

endmodule

// File: rtl/blit_scheduler.sv
// rtl/blit_scheduler.sv - round-robin rectangle-blit scheduler feeding the burst pixel writer
// Optional colour keying of transparent pixels: BLIT_TRANSPARENT_KEY_EN
module blit_scheduler
  import blit_pkg::*;
#(
  parameter int         NREQ  = 4,
  parameter int         H_RES = 800,
  parameter int         V_RES = 600,
  parameter logic [7:0] KEY   = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             fb_baseaddr,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*COORD_W-1:0] req_x,
  input  logic [NREQ*COORD_W-1:0] req_y,
  input  logic [NREQ*COORD_W-1:0] req_w,
  input  logic [NREQ*COORD_W-1:0] req_h,
  input  logic [NREQ*8-1:0]       src_data,
  input  logic [NREQ-1:0]         src_valid,
  output logic [NREQ-1:0]         src_ready,
  output logic [31:0]             wr_baseaddr,
  output logic [COORD_W-1:0]      wr_x,
  output logic [COORD_W-1:0]      wr_y,
  output logic [COORD_W-1:0]      wr_width,
  output logic [COORD_W-1:0]      wr_height,
  output logic [7:0]              wr_data,
  output logic                    wr_valid,
  output logic                    wr_draw,
  input  logic                    wr_ready,
  input  logic                    wr_bvalid,
  output logic                    busy,
  output logic [2:0]              grant_id
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  blit_state_e            state_q, state_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [2:0]             grant_id_q, grant_id_d;
  logic [NREQ-1:0]        req_ready_q, req_ready_d;
  logic [COORD_W-1:0]     x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0]     w_q, w_d, h_q, h_d;
  logic [31:0]            base_q, base_d;
  logic [COORD_W:0]       cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0]     col_q, col_d, row_q, row_d;
  logic [RESP_CNT_W-1:0]  resp_cnt_q, resp_cnt_d;

  logic [COORD_W-1:0]     rx [NREQ];
  logic [COORD_W-1:0]     ry [NREQ];
  logic [COORD_W-1:0]     rw [NREQ];
  logic [COORD_W-1:0]     rh [NREQ];
  logic [7:0]             rd [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rx[i] = req_x[COORD_W*i +: COORD_W];
    assign ry[i] = req_y[COORD_W*i +: COORD_W];
    assign rw[i] = req_w[COORD_W*i +: COORD_W];
    assign rh[i] = req_h[COORD_W*i +: COORD_W];
    assign rd[i] = src_data[8*i +: 8];
  end

  logic [NREQ-1:0]        arb_grant;
  logic [2:0]             arb_idx;
  logic                   arb_any;
  logic [IDX_W-1:0]       arb_sel;
  logic [IDX_W-1:0]       gsel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign arb_sel = arb_idx[IDX_W-1:0];
  assign gsel    = grant_id_q[IDX_W-1:0];

  logic                   in_stream;
  logic                   sel_valid;
  logic [7:0]             sel_data;
  logic                   beat;
  logic                   key_ok;
  logic [RESP_CNT_W-1:0]  resp_need;
  logic [RESP_CNT_W-1:0]  resp_next;
  logic [2:0]             ptr_after;

  assign in_stream = (state_q == STREAM);
  assign sel_valid = src_valid[gsel];
  assign sel_data  = rd[gsel];
  assign beat      = in_stream & sel_valid & wr_ready;
  assign resp_need = resp_total(w_q, h_q);
  assign resp_next = resp_cnt_q + RESP_CNT_W'(wr_bvalid);
  assign ptr_after = (int'(grant_id_q) == NREQ - 1) ? 3'd0 : grant_id_q + 3'd1;

`ifdef BLIT_TRANSPARENT_KEY_EN
  assign key_ok = (sel_data != KEY);
`else
  logic key_unused;
  assign key_ok     = 1'b1;
  assign key_unused = ^KEY;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    base_d      = base_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    col_d       = col_q;
    row_d       = row_q;
    resp_cnt_d  = resp_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready_d = arb_grant;
          grant_id_d  = arb_idx;
          x0_d        = rx[arb_sel];
          y0_d        = ry[arb_sel];
          w_d         = rw[arb_sel];
          h_d         = rh[arb_sel];
          base_d      = fb_baseaddr;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        cx_d       = {1'b0, x0_q};
        cy_d       = {1'b0, y0_q};
        col_d      = '0;
        row_d      = '0;
        resp_cnt_d = '0;
        state_d    = STREAM;
      end
      STREAM: begin
        // Responses for early bursts can come back before the last pixel is accepted.
        resp_cnt_d = resp_next;
        if (beat) begin
          if (col_q == w_q) begin
            col_d = '0;
            cx_d  = {1'b0, x0_q};
            if (row_q == h_q) begin
              state_d = DRAIN;
            end else begin
              row_d = row_q + 1'b1;
              cy_d  = cy_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
            cx_d  = cx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        resp_cnt_d = resp_next;
        if (resp_next >= resp_need) begin
          rr_ptr_d = ptr_after;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      base_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      resp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      base_q      <= base_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      resp_cnt_q  <= resp_cnt_d;
    end
  end

  always_comb begin
    src_ready = '0;
    if (in_stream) src_ready[gsel] = wr_ready;
  end

  assign req_ready   = req_ready_q;
  assign wr_valid    = in_stream & sel_valid;
  assign wr_data     = in_stream ? sel_data : 8'h00;
  // Clipped and keyed pixels are still consumed; only the byte strobe is suppressed.
  assign wr_draw     = in_stream & (cx_q < (COORD_W+1)'(H_RES)) &
                       (cy_q < (COORD_W+1)'(V_RES)) & key_ok;
  assign wr_x        = cx_q[COORD_W-1:0];
  assign wr_y        = cy_q[COORD_W-1:0];
  assign wr_width    = w_q;
  assign wr_height   = h_q;
  assign wr_baseaddr = base_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;

endmodule
